// File: rtl/regfile_port_sequencer.sv
// Serialises two-operand reads and single writes onto a single-port 32x32 register file.
// Define RFSEQ_BYPASS_EN to forward a stalled writeback into an in-flight operand read.
module rfseq_operand (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_i,
  input  logic        zero_i,
  input  logic [31:0] src_i,
  output logic [31:0] data_o
);
  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (cap_i) data_d = zero_i ? 32'h0 : src_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) data_q <= 32'h0;
    else      data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module regfile_port_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rs1_data,
  output logic [31:0]       rs2_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic [31:0]       reg_addr,
  output logic              reg_we,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata
);
  localparam int NUM_OPND = 2;

  typedef enum logic [1:0] {IDLE, READ1, READ2, RESP} state_e;

  state_e                             state_q, state_d;
  logic [NUM_OPND-1:0][ADDR_W-1:0]    rs_q, rs_d;
  logic [NUM_OPND-1:0]                cap;
  logic [NUM_OPND-1:0][31:0]          src;
  logic [NUM_OPND-1:0][31:0]          opnd;
  logic                               rsp_valid_q;

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    cap       = '0;
    req_ready = 1'b0;
    wb_ready  = 1'b0;
    reg_addr  = 32'h0;
    reg_we    = 1'b0;
    reg_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        // Writes win the port; a concurrent read waits for a write-free cycle.
        wb_ready  = rst;
        req_ready = rst && !wb_valid;
        if (wb_valid) begin
          reg_addr  = 32'(wb_rd);
          reg_we    = rst && (wb_rd != '0);
          reg_wdata = wb_data;
        end else if (req_valid) begin
          rs_d    = {req_rs2, req_rs1};
          state_d = READ1;
        end
      end
      READ1: begin
        reg_addr = 32'(rs_q[0]);
        cap[0]   = 1'b1;
        state_d  = READ2;
      end
      READ2: begin
        reg_addr = 32'(rs_q[1]);
        cap[1]   = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rs_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      rsp_valid_q <= (state_d == RESP);
    end
  end

  for (genvar i = 0; i < NUM_OPND; i++) begin : g_opnd
`ifdef RFSEQ_BYPASS_EN
    // The stalled write is still performed later in IDLE; only its data is forwarded.
    assign src[i] = (wb_valid && (wb_rd == rs_q[i]) && (rs_q[i] != '0)) ? wb_data : reg_rdata;
`else
    assign src[i] = reg_rdata;
`endif
    rfseq_operand u_opnd (
      .clk    (clk),
      .rst    (rst),
      .cap_i  (cap[i]),
      .zero_i (rs_q[i] == '0),
      .src_i  (src[i]),
      .data_o (opnd[i])
    );
  end

  assign rsp_valid = rsp_valid_q;
  assign rs1_data  = opnd[0];
  assign rs2_data  = opnd[1];
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Scoreboard bench for regfile_port_sequencer: directed scenarios then randomized traffic.
module tb_regfile_port_sequencer;
  localparam int ADDR_W = 5;
`ifdef RFSEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [ADDR_W-1:0] req_rs1 = '0, req_rs2 = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rs1_data, rs2_data;
  logic wb_valid = 1'b0, wb_ready;
  logic [ADDR_W-1:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we;

  logic [31:0] rf [32];
  logic [31:0] seed [32];
  logic [31:0] model [32];
  bit seeding = 1'b1;

  int tests = 0, fails = 0;

  typedef struct {
    logic [ADDR_W-1:0] rs1, rs2;
    logic [31:0] d1, d2;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  bit wb_fire = 1'b0, req_fire = 1'b0;
  int rd_phase = 0;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // Register file array model: combinational read, write on the clock edge.
  assign reg_rdata = rf[reg_addr[4:0]];
  always @(posedge clk) begin
    if (seeding) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed[i];
    end else if (reg_we) begin
      rf[reg_addr[4:0]] <= reg_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Observer: records accepted writes/reads into the architectural model and scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      wb_fire  = 1'b0;
      req_fire = 1'b0;
      rd_phase = 0;
      sb_q.delete();
    end else begin
      wb_fire  = wb_valid && wb_ready;
      req_fire = req_valid && req_ready;
      if (BYP && sb_q.size() > 0 && wb_valid && wb_rd != '0) begin
        if (rd_phase == 1 && wb_rd == sb_q[sb_q.size()-1].rs1) sb_q[sb_q.size()-1].d1 = wb_data;
        if (rd_phase == 2 && wb_rd == sb_q[sb_q.size()-1].rs2) sb_q[sb_q.size()-1].d2 = wb_data;
      end
      if (req_fire) sb_q.push_back('{req_rs1, req_rs2, model[req_rs1], model[req_rs2]});
    end
    @(posedge clk);
    if (wb_fire && wb_rd != '0) model[wb_rd] = wb_data;
    rd_phase = req_fire ? 1 : (rd_phase == 1 ? 2 : 0);
  end

  // Monitor: compares every response handshake against the scoreboard head.
  always begin
    @(negedge clk);
    #2;
    if (rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
      end else if (rsp_ready) begin
        mon_e = sb_q.pop_front();
        check("rsp_rs1", rs1_data, mon_e.d1);
        check("rsp_rs2", rs2_data, mon_e.d2);
      end
    end
  end

  // Called in the READ1 cycle; returns with the bench sitting in the first RESP cycle.
  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!rsp_valid && k < 10);
    check({name, "_latency"}, 32'(k), 32'd2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      seed[i]  = $urandom;
      model[i] = (i == 0) ? 32'h0 : seed[i];
    end
    repeat (2) @(negedge clk);
    seeding = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rs1", rs1_data, 32'h0);
    check("rst_rs2", rs2_data, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_reg_addr", reg_addr, 32'h0);
    rsp_ready = 1'b1;

    // Write x5, then read x5/x0.
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("wr5_we", 32'(reg_we), 32'd1);
    check("wr5_addr", reg_addr, 32'd5);
    check("wr5_wdata", reg_wdata, 32'hDEADBEEF);
    check("wr5_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0;
    #1;
    check("rd5_we_idle", 32'(reg_we), 32'd0);
    check("rd5_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 1'b0;
    wait_rsp("rd5");
    check("rd5_rs1", rs1_data, 32'hDEADBEEF);
    check("rd5_rs2", rs2_data, 32'h0);

    // Simultaneous write and read: the write goes first.
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd5;
    #1;
    check("sim_req_ready", 32'(req_ready), 32'd0);
    check("sim_we", 32'(reg_we), 32'd1);
    check("sim_addr", reg_addr, 32'd3);
    @(negedge clk); wb_valid = 1'b0;
    #1;
    check("sim_req_ready2", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 1'b0;
    wait_rsp("sim");
    check("sim_rs1", rs1_data, 32'h11);

    // Write to x0 is dropped.
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    check("x0_wb_ready", 32'(wb_ready), 32'd1);
    check("x0_we", 32'(reg_we), 32'd0);
    @(negedge clk); wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
    @(negedge clk); req_valid = 1'b0;
    wait_rsp("x0");
    check("x0_rs1", rs1_data, 32'h0);

    // Back-pressure in RESP with a write waiting.
    @(negedge clk); rsp_ready = 1'b0; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd3;
    @(negedge clk); req_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rs1", rs1_data, 32'hDEADBEEF);
      check("hold_rs2", rs2_data, 32'h11);
      check("hold_wb_ready", 32'(wb_ready), 32'd0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rel_wb_ready", 32'(wb_ready), 32'd1);
    check("rel_we", 32'(reg_we), 32'd1);
    check("rel_addr", reg_addr, 32'd9);
    @(negedge clk); wb_valid = 1'b0;

    // Write raised during READ1 of the same index.
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1;
    @(negedge clk); wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd0;
    @(negedge clk); req_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h9;
    #1;
    check("byp_wb_stall", 32'(wb_ready), 32'd0);
    wait_rsp("byp");
    check("byp_rs1", rs1_data, BYP ? 32'h9 : 32'h1);
    @(negedge clk);
    #1;
    check("byp_late_we", 32'(reg_we), 32'd1);
    check("byp_late_wdata", reg_wdata, 32'h9);
    @(negedge clk); wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7;
    @(negedge clk); req_valid = 1'b0;
    wait_rsp("x7");
    check("x7_rs1", rs1_data, 32'h9);
    check("x7_rs2", rs2_data, 32'h9);

    // Reset during READ1 aborts the read and suppresses a pending write.
    @(negedge clk); req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd3;
    @(negedge clk); req_valid = 1'b0; rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    #1;
    check("mrst_we1", 32'(reg_we), 32'd0);
    @(negedge clk);
    #1;
    check("mrst_we2", 32'(reg_we), 32'd0);
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_rs1", rs1_data, 32'h0);
    check("mrst_rs2", rs2_data, 32'h0);
    @(negedge clk); rst = 1'b1; wb_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Randomized traffic; requests are held until their handshake.
    for (int it = 0; it < 800; it++) begin
      @(negedge clk);
      if (wb_valid && wb_fire) wb_valid = 1'b0;
      if (req_valid && req_fire) req_valid = 1'b0;
      if (!wb_valid && $urandom_range(3) == 0) begin
        wb_valid = 1'b1; wb_rd = 5'($urandom_range(7)); wb_data = $urandom;
      end
      if (!req_valid && $urandom_range(2) == 0) begin
        req_valid = 1'b1; req_rs1 = 5'($urandom_range(7)); req_rs2 = 5'($urandom_range(7));
      end
      rsp_ready = ($urandom_range(2) != 0);
    end
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      if (wb_valid && wb_fire) wb_valid = 1'b0;
      if (req_valid && req_fire) req_valid = 1'b0;
      rsp_ready = 1'b1;
      if (!wb_valid && !req_valid && !rsp_valid && sb_q.size() == 0 && rd_phase == 0) break;
    end
    @(negedge clk);
    #3;
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("drain_wb_done", 32'(wb_valid), 32'd0);
    check("drain_req_done", 32'(req_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
